// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - 2-D Speed Pong ball motion, wall/paddle bounce, speed-up and miss scoring
module ball_engine #(
    parameter int COORD_W     = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 10,
    parameter int PAD_X_L     = 20,
    parameter int PAD_X_R     = 610,
    parameter int PAD_W       = 10,
    parameter int SPEED_MIN   = 1,
    parameter int SPEED_MAX   = 8,
    parameter int SERVE_TICKS = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [COORD_W-1:0] pad1_top,
    input  logic [COORD_W-1:0] pad1_bot,
    input  logic [COORD_W-1:0] pad2_top,
    input  logic [COORD_W-1:0] pad2_bot,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               ball_dx_neg,
    output logic               ball_dy_neg,
    output logic [3:0]         speed,
    output logic               score_p1,
    output logic               score_p2,
    output logic [1:0]         state
);

    localparam int CW = $clog2(SERVE_TICKS + 1);

    localparam logic [COORD_W-1:0] X_C    = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] Y_C    = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [COORD_W:0]   X_MAX  = (COORD_W+1)'(SCREEN_W - BALL_SIZE);
    localparam logic [COORD_W:0]   Y_MAX  = (COORD_W+1)'(SCREEN_H - BALL_SIZE);
    localparam logic [COORD_W:0]   BS     = (COORD_W+1)'(BALL_SIZE);
    localparam logic [COORD_W:0]   FACE_L = (COORD_W+1)'(PAD_X_L + PAD_W);
    localparam logic [COORD_W:0]   FACE_R = (COORD_W+1)'(PAD_X_R);
    localparam logic [COORD_W-1:0] X_HIT_R = COORD_W'(PAD_X_R - BALL_SIZE);
    localparam logic [3:0]         SP_MIN = 4'(SPEED_MIN);
    localparam logic [3:0]         SP_MAX = 4'(SPEED_MAX);
    localparam logic [CW-1:0]      CNT_LOAD = CW'(SERVE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_SCORED = 2'd3
    } state_t;

    state_t             st;
    logic [COORD_W-1:0] x_r, y_r;
    logic               dxn_r, dyn_r;
    logic [3:0]         sp_r;
    logic               p1_r, p2_r;
    logic [CW-1:0]      cnt;

    logic [COORD_W:0]   x_e, y_e, s_e;
    logic               ov1, ov2;
    logic [COORD_W-1:0] nx, ny;
    logic               ndx, ndy, hit, miss_l, miss_r;
    logic [3:0]         sp_inc;

    // All geometry is evaluated one bit wider so sums and differences never wrap.
    always_comb begin
        x_e    = {1'b0, x_r};
        y_e    = {1'b0, y_r};
        s_e    = {{(COORD_W-3){1'b0}}, sp_r};
        ov1    = (y_e + BS > {1'b0, pad1_top}) && (y_e < {1'b0, pad1_bot});
        ov2    = (y_e + BS > {1'b0, pad2_top}) && (y_e < {1'b0, pad2_bot});
        sp_inc = (sp_r >= SP_MAX) ? SP_MAX : sp_r + 4'd1;
        ny     = y_r;
        ndy    = dyn_r;
        nx     = x_r;
        ndx    = dxn_r;
        hit    = 1'b0;
        miss_l = 1'b0;
        miss_r = 1'b0;

        if (!dyn_r) begin
            if (y_e + s_e > Y_MAX) begin
                ny  = Y_MAX[COORD_W-1:0];
                ndy = 1'b1;
            end else begin
                ny  = COORD_W'(y_e + s_e);
            end
        end else if (y_e < s_e) begin
            ny  = '0;
            ndy = 1'b0;
        end else begin
            ny  = COORD_W'(y_e - s_e);
        end

        if (dxn_r) begin
            if ((x_e < FACE_L + s_e) && ov1) begin
                nx  = FACE_L[COORD_W-1:0];
                ndx = 1'b0;
                hit = 1'b1;
            end else if (x_e < s_e) begin
                miss_l = 1'b1;
            end else begin
                nx = COORD_W'(x_e - s_e);
            end
        end else begin
            if ((x_e + BS + s_e >= FACE_R) && ov2) begin
                nx  = X_HIT_R;
                ndx = 1'b1;
                hit = 1'b1;
            end else if (x_e + s_e > X_MAX) begin
                miss_r = 1'b1;
            end else begin
                nx = COORD_W'(x_e + s_e);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= ST_IDLE;
            x_r   <= X_C;
            y_r   <= Y_C;
            dxn_r <= 1'b0;
            dyn_r <= 1'b0;
            sp_r  <= SP_MIN;
            p1_r  <= 1'b0;
            p2_r  <= 1'b0;
            cnt   <= '0;
        end else begin
            p1_r <= 1'b0;
            p2_r <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st  <= ST_SERVE;
                        cnt <= CNT_LOAD;
                    end
                end
                ST_SERVE: begin
                    if (tick) begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            st <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (miss_l || miss_r) begin
                            // Recentre immediately so the SCORED cycle already shows the serve position.
                            st    <= ST_SCORED;
                            p1_r  <= miss_r;
                            p2_r  <= miss_l;
                            x_r   <= X_C;
                            y_r   <= Y_C;
                            dxn_r <= miss_l;
                            dyn_r <= 1'b0;
                            sp_r  <= SP_MIN;
                            cnt   <= CNT_LOAD;
                        end else begin
                            x_r   <= nx;
                            y_r   <= ny;
                            dxn_r <= ndx;
                            dyn_r <= ndy;
                            if (hit)
                                sp_r <= sp_inc;
                        end
                    end
                end
                ST_SCORED: begin
                    st <= ST_SERVE;
                end
            endcase
        end
    end

    assign ball_x      = x_r;
    assign ball_y      = y_r;
    assign ball_dx_neg = dxn_r;
    assign ball_dy_neg = dyn_r;
    assign speed       = sp_r;
    assign score_p1    = p1_r;
    assign score_p2    = p2_r;
    assign state       = st;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - directed scoreboard bench for ball_engine with SERVE_TICKS=4
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] pad1_top = 10'd0, pad1_bot = 10'd480;
    logic [9:0] pad2_top = 10'd0, pad2_bot = 10'd480;
    logic [9:0] ball_x, ball_y;
    logic       ball_dx_neg, ball_dy_neg;
    logic [3:0] speed;
    logic       score_p1, score_p2;
    logic [1:0] state;

    ball_engine #(.SERVE_TICKS(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .pad1_top(pad1_top), .pad1_bot(pad1_bot),
        .pad2_top(pad2_top), .pad2_bot(pad2_bot),
        .ball_x(ball_x), .ball_y(ball_y),
        .ball_dx_neg(ball_dx_neg), .ball_dy_neg(ball_dy_neg),
        .speed(speed), .score_p1(score_p1), .score_p2(score_p2), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int m_x, m_y, m_dxn, m_dyn, m_sp, m_st, m_cnt, m_p1, m_p2;
    logic [29:0] sbq[$];

    task automatic model_reset();
        m_x = 315; m_y = 235; m_dxn = 0; m_dyn = 0; m_sp = 1;
        m_st = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0;
        sbq.delete();
    endtask

    task automatic model_step();
        int ov1, ov2, nx, ny, ndx, ndy, miss;
        m_p1 = 0; m_p2 = 0;
        if (m_st == 0) begin
            if (start) begin m_st = 1; m_cnt = 4; end
        end else if (m_st == 1) begin
            if (tick) begin
                if (m_cnt == 1) m_st = 2;
                m_cnt = m_cnt - 1;
            end
        end else if (m_st == 3) begin
            m_st = 1;
        end else if (tick) begin
            ov1 = (m_y + 10 > int'(pad1_top)) && (m_y < int'(pad1_bot));
            ov2 = (m_y + 10 > int'(pad2_top)) && (m_y < int'(pad2_bot));
            ndy = m_dyn;
            if (m_dyn == 0) begin
                ny = m_y + m_sp;
                if (ny > 470) begin ny = 470; ndy = 1; end
            end else begin
                ny = m_y - m_sp;
                if (ny < 0) begin ny = 0; ndy = 0; end
            end
            ndx = m_dxn; miss = 0; nx = m_x;
            if (m_dxn == 1) begin
                if (m_x - m_sp < 30 && ov1 != 0) begin
                    nx = 30; ndx = 0; m_sp = (m_sp + 1 > 8) ? 8 : m_sp + 1;
                end else if (m_x - m_sp < 0) begin
                    miss = 1; m_p2 = 1;
                end else nx = m_x - m_sp;
            end else begin
                if (m_x + 10 + m_sp >= 610 && ov2 != 0) begin
                    nx = 600; ndx = 1; m_sp = (m_sp + 1 > 8) ? 8 : m_sp + 1;
                end else if (m_x + m_sp > 630) begin
                    miss = 1; m_p1 = 1;
                end else nx = m_x + m_sp;
            end
            if (miss != 0) begin
                m_x = 315; m_y = 235; m_sp = 1; m_dyn = 0;
                m_dxn = m_p2; m_st = 3; m_cnt = 4;
            end else begin
                m_x = nx; m_y = ny; m_dxn = ndx; m_dyn = ndy;
            end
        end
    endtask

    function automatic logic [29:0] model_vec();
        return {10'(m_x), 10'(m_y), 1'(m_dxn), 1'(m_dyn), 4'(m_sp), 2'(m_st), 1'(m_p1), 1'(m_p2)};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle: push the model's prediction, clock, then pop and compare.
    task automatic step(input logic t, input logic s);
        logic [29:0] exp_v, obs_v;
        tick = t; start = s;
        model_step();
        sbq.push_back(model_vec());
        @(posedge clk); #1;
        cyc++;
        exp_v = sbq.pop_front();
        obs_v = {ball_x, ball_y, ball_dx_neg, ball_dy_neg, speed, state, score_p1, score_p2};
        n_vec++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL scoreboard cycle %0d: observed %h, expected %h", cyc, obs_v, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, ball_x, 315);
        chk({tag, "_y"}, ball_y, 235);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_speed"}, speed, 1);
        chk({tag, "_dirs"}, {ball_dx_neg, ball_dy_neg, score_p1, score_p2}, 0);
    endtask

    initial begin
        int n, d0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;

        repeat (3) step(1, 0);
        chk("idle_hold_x", ball_x, 315);
        chk("idle_state", state, 0);

        step(0, 1);
        chk("serve_entry", state, 1);
        repeat (3) step(1, 1);
        chk("serve_after3", state, 1);
        step(1, 1);
        chk("play_after4", state, 2);
        step(1, 0);
        chk("first_move_x", ball_x, 316);
        chk("first_move_y", ball_y, 236);

        n = 0;
        while (m_y != 470 && n < 1000) begin step(1, 0); n++; end
        chk("reach_y470", ball_y, 470);
        chk("y470_dy", ball_dy_neg, 0);
        step(1, 0);
        chk("bottom_clamp_y", ball_y, 470);
        chk("bottom_clamp_dy", ball_dy_neg, 1);
        step(1, 0);
        chk("bottom_up_y", ball_y, 469);

        n = 0;
        while (!(m_x == 599 && m_dxn == 0) && n < 1000) begin step(1, 0); n++; end
        chk("reach_x599", ball_x, 599);
        step(1, 0);
        chk("pad2_hit_x", ball_x, 600);
        chk("pad2_hit_dx", ball_dx_neg, 1);
        chk("pad2_hit_speed", speed, 2);

        n = 0;
        while (m_sp != 8 && n < 6000) begin step(1, 0); n++; end
        chk("speed_reach8", speed, 8);
        d0 = m_dxn;
        n = 0;
        while (m_dxn == d0 && n < 2000) begin step(1, 0); n++; end
        chk("speed_sat8", speed, 8);
        chk("sat_hit_x", ball_x, (d0 == 1) ? 30 : 600);

        pad2_top = 10'd0; pad2_bot = 10'd40;
        n = 0;
        while (m_p1 == 0 && n < 3000) begin step(1, 0); n++; end
        chk("miss_r_pulse", score_p1, 1);
        chk("miss_r_x", ball_x, 315);
        chk("miss_r_y", ball_y, 235);
        chk("miss_r_speed", speed, 1);
        chk("miss_r_state", state, 3);
        chk("miss_r_dx", ball_dx_neg, 0);
        step(1, 1);
        chk("scored_to_serve", state, 1);
        chk("pulse_one_cycle", score_p1, 0);

        repeat (4) step(1, 0);
        chk("reserve_play", state, 2);
        pad1_top = 10'd0; pad1_bot = 10'd0;
        pad2_top = 10'd0; pad2_bot = 10'd480;
        n = 0;
        while (m_p2 == 0 && n < 3000) begin step(1, 0); n++; end
        chk("miss_l_pulse", score_p2, 1);
        chk("miss_l_dx", ball_dx_neg, 1);
        chk("miss_l_state", state, 3);
        step(0, 0);
        chk("miss_l_serve", state, 1);

        pad1_top = 10'd100; pad1_bot = 10'd300;
        repeat (4) step(1, 0);
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("pre_reset_play", state, 2);
        #3 reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, 0);
        chk("post_reset_idle", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
